// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard -- decode-stage hazard unit for the pipelined MIPS core.
// A shift-register scoreboard of in-flight register writers (entry 0 = E,
// 1 = M, 2 = W, ...) yields the D-stage stall and per-operand forward selects.
// Optional multiply/divide busy tracker: define HAZARD_MD_EN to build it in;
// without it md_busy is 0 and the HI/LO inputs are ignored.
module hazard_scoreboard #(
   parameter int STAGES      = 3,
   parameter int AW          = 5,
   parameter int TW          = 2,
   parameter int SELW        = $clog2(STAGES + 1),
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   rs,
   input  logic [AW-1:0]   rt,
   input  logic [TW-1:0]   tuse_rs,
   input  logic [TW-1:0]   tuse_rt,
   input  logic [AW-1:0]   dst,
   input  logic [TW-1:0]   tnew,
   input  logic            md_start,
   input  logic            md_is_div,
   input  logic            md_use,
   output logic            stall,
   output logic [SELW-1:0] fwd_rs_sel,
   output logic [SELW-1:0] fwd_rt_sel,
   output logic            md_busy
);

   // Writer scoreboard: destination and remaining cycles until its result exists.
   logic [AW-1:0] r_addr [STAGES];
   logic [TW-1:0] r_tnew [STAGES];

   logic w_rs_stall;
   logic w_rt_stall;
   logic w_md_stall;

   // Nearest-writer lookup per operand; walking oldest to newest lets the
   // youngest match overwrite older ones, so a nearer writer always shadows.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      w_rs_stall = 1'b0;
      w_rt_stall = 1'b0;
      fwd_rs_sel = '0;
      fwd_rt_sel = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         if (rs != '0 && r_addr[k] == rs) begin
            w_rs_stall = (tuse_rs < r_tnew[k]);
            fwd_rs_sel = (r_tnew[k] == '0) ? SELW'(k + 1) : '0;
         end
         if (rt != '0 && r_addr[k] == rt) begin
            w_rt_stall = (tuse_rt < r_tnew[k]);
            fwd_rt_sel = (r_tnew[k] == '0) ? SELW'(k + 1) : '0;
         end
      end
   end

   // Advance the writer pipeline; D's write enters E unless D is being held.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the scoreboard is a handful of flops, not a RAM, so every entry is reset.
         for (int k = 0; k < STAGES; k++) begin
            r_addr[k] <= '0;
            r_tnew[k] <= '0;
         end
      end else begin
         // NOTE: non-blocking, so each entry takes its neighbour's pre-edge value.
         r_addr[0] <= stall ? '0 : dst;
         r_tnew[0] <= stall ? '0 : tnew;
         for (int k = 1; k < STAGES; k++) begin
            r_addr[k] <= r_addr[k-1];
            r_tnew[k] <= (r_tnew[k-1] == '0) ? '0 : r_tnew[k-1] - TW'(1);
         end
      end
   end

`ifdef HAZARD_MD_EN
   localparam int CMAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   logic [CW-1:0] r_md_cnt;

   // Busy down-counter; a start held by a stall loads nothing and retries.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_md_cnt <= '0;
      end else if (md_start && !stall) begin
         r_md_cnt <= md_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (r_md_cnt != '0) begin
         r_md_cnt <= r_md_cnt - CW'(1);
      end
   end

   assign md_busy    = (r_md_cnt != '0);
   assign w_md_stall = md_use & md_busy;
`else
   logic w_unused_md;

   assign w_unused_md = ^{md_start, md_is_div, md_use, (MULT_CYCLES != DIV_CYCLES)};
   assign md_busy     = 1'b0;
   assign w_md_stall  = 1'b0;
`endif

   assign stall = w_rs_stall | w_rt_stall | w_md_stall;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, hand-written MD
// sequences, then random stimulus against a behavioural reference model.
module tb_hazard_scoreboard;

   localparam int STAGES = 3;
   localparam int AW     = 5;
   localparam int TW     = 2;
   localparam int SELW   = 2;
   localparam int MULT_C = 5;
   localparam int DIV_C  = 10;
`ifdef HAZARD_MD_EN
   localparam int MD_EN = 1;
`else
   localparam int MD_EN = 0;
`endif

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [AW-1:0]   rs = '0, rt = '0, dst = '0;
   logic [TW-1:0]   tuse_rs = '0, tuse_rt = '0, tnew = '0;
   logic            md_start = 1'b0, md_is_div = 1'b0, md_use = 1'b0;
   logic            stall, md_busy;
   logic [SELW-1:0] fwd_rs_sel, fwd_rt_sel;

   always #5 clk = ~clk;

   hazard_scoreboard #(
      .STAGES(STAGES), .AW(AW), .TW(TW), .SELW(SELW),
      .MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C)
   ) dut (
      .clk(clk), .reset(reset), .rs(rs), .rt(rt),
      .tuse_rs(tuse_rs), .tuse_rt(tuse_rt), .dst(dst), .tnew(tnew),
      .md_start(md_start), .md_is_div(md_is_div), .md_use(md_use),
      .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
      .md_busy(md_busy)
   );

   typedef struct {
      bit reset;
      int rs, rt, trs, trt, dst, tnew;
      bit md_start, md_is_div, md_use;
      int e_stall, e_rs, e_rt, e_busy;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // hist[a] is the write that entered E a edges ago; its remaining latency
   // is simply its issue-time tnew minus a, floored at zero.
   typedef struct { int addr; int tnew; } ent_t;
   ent_t hist[$];
   int   cyc     = 0;
   int   md_last = -1;   // last cycle index in which the MD unit is busy

   function automatic void lookup(input int x, input int tu, output int st, output int sel);
      st  = 0;
      sel = 0;
      if (x == 0) return;
      for (int k = 0; k < STAGES; k++) begin
         int a;
         int eff;
         a   = (k < hist.size()) ? hist[k].addr : 0;
         eff = (k < hist.size()) ? hist[k].tnew - k : 0;
         if (eff < 0) eff = 0;
         if (a == x) begin
            st  = (tu < eff) ? 1 : 0;
            sel = (eff == 0) ? k + 1 : 0;
            return;
         end
      end
   endfunction

   function automatic void model_eval(input vec_t v, output int st, output int s_rs,
                                      output int s_rt, output int busy);
      int st_rs, st_rt;
      lookup(v.rs, v.trs, st_rs, s_rs);
      lookup(v.rt, v.trt, st_rt, s_rt);
      busy = (MD_EN != 0 && cyc <= md_last) ? 1 : 0;
      st   = (st_rs != 0 || st_rt != 0 || (v.md_use && busy != 0)) ? 1 : 0;
   endfunction

   function automatic void model_edge(input vec_t v, input int st);
      ent_t e;
      if (v.reset) begin
         hist.delete();
         cyc     = 0;
         md_last = -1;
      end else begin
         e.addr = (st != 0) ? 0 : v.dst;
         e.tnew = (st != 0) ? 0 : v.tnew;
         hist.push_front(e);
         if (hist.size() > STAGES) void'(hist.pop_back());
         if (MD_EN != 0 && v.md_start && st == 0)
            md_last = cyc + (v.md_is_div ? DIV_C : MULT_C);
         cyc++;
      end
   endfunction

   // ---------------- stimulus helpers ----------------
   function automatic vec_t sb(input int rs_, rt_, trs, trt, dst_, tnew_, es, ers, ert);
      vec_t v;
      v = '{reset: 1'b0, rs: rs_, rt: rt_, trs: trs, trt: trt, dst: dst_, tnew: tnew_,
            md_start: 1'b0, md_is_div: 1'b0, md_use: 1'b0,
            e_stall: es, e_rs: ers, e_rt: ert, e_busy: 0};
      return v;
   endfunction

   function automatic vec_t mdv(input bit start, input bit div, input bit use_, input bit rst,
                                input int es, input int eb);
      vec_t v;
      v = sb(0, 0, 3, 3, 0, 0, es, 0, 0);
      v.md_start = start;
      v.md_is_div = div;
      v.md_use = use_;
      v.reset = rst;
      v.e_busy = eb;
      return v;
   endfunction

   // Drive one D-stage cycle at the falling edge, compare just after, clock it in.
   task automatic step(input vec_t v, input string tag);
      int st, s_rs, s_rt, b;
      @(negedge clk);
      reset     = v.reset;
      rs        = AW'(v.rs);
      rt        = AW'(v.rt);
      tuse_rs   = TW'(v.trs);
      tuse_rt   = TW'(v.trt);
      dst       = AW'(v.dst);
      tnew      = TW'(v.tnew);
      md_start  = v.md_start;
      md_is_div = v.md_is_div;
      md_use    = v.md_use;
      #1;
      check({tag, " stall"},   int'(stall),      v.e_stall);
      check({tag, " rs_sel"},  int'(fwd_rs_sel), v.e_rs);
      check({tag, " rt_sel"},  int'(fwd_rt_sel), v.e_rt);
      check({tag, " md_busy"}, int'(md_busy),    v.e_busy);
      model_eval(v, st, s_rs, s_rt, b);
      @(posedge clk);
      model_edge(v, st);
   endtask

   vec_t tbl[$];
   vec_t v;

   initial begin
      // Fields: rs, rt, tuse_rs, tuse_rt, dst, tnew -> stall, rs_sel, rt_sel
      tbl.push_back(sb( 0,  0, 3, 3,  0, 0,  0, 0, 0));  // reset state
      tbl.push_back(sb( 0,  0, 3, 3,  8, 2,  0, 0, 0));  // lw $8
      tbl.push_back(sb( 8,  0, 1, 3, 10, 1,  1, 0, 0));  // add: load-use stall
      tbl.push_back(sb( 8,  0, 1, 3, 10, 1,  0, 0, 0));  // load still one cycle from ready
      tbl.push_back(sb( 8, 10, 2, 0,  0, 0,  1, 3, 0));  // rs from W, rt stalls on E
      tbl.push_back(sb( 0,  0, 3, 3,  0, 0,  0, 0, 0));
      tbl.push_back(sb( 0,  0, 3, 3,  9, 1,  0, 0, 0));  // ori $9
      tbl.push_back(sb( 0,  9, 3, 0,  0, 0,  1, 0, 0));  // beq stalls one cycle
      tbl.push_back(sb( 0,  9, 3, 0,  0, 0,  0, 0, 2));  // then forwards from M
      tbl.push_back(sb( 0,  0, 3, 3, 31, 0,  0, 0, 0));  // jal
      tbl.push_back(sb(31,  0, 0, 3,  0, 0,  0, 1, 0));  // jr forwards from E
      tbl.push_back(sb( 0,  0, 3, 3,  5, 1,  0, 0, 0));  // ori $5
      tbl.push_back(sb( 0,  0, 3, 3,  5, 2,  0, 0, 0));  // lw $5
      tbl.push_back(sb( 5,  5, 1, 3,  7, 1,  1, 0, 0));  // nearer lw shadows ori
      tbl.push_back(sb( 5,  5, 1, 3,  7, 1,  0, 0, 0));  // M lw (tnew 1) shadows W
      tbl.push_back(sb( 5,  5, 3, 3,  0, 0,  0, 3, 3));  // rs == rt: same select
      tbl.push_back(sb( 0,  0, 3, 3,  0, 2,  0, 0, 0));  // write to $0
      tbl.push_back(sb( 0,  0, 0, 0,  0, 0,  0, 0, 0));  // $0 never matches
      tbl.push_back(sb( 0,  0, 0, 0,  0, 0,  0, 0, 0));

      // Initial reset (outputs unknown before it, so nothing is compared).
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      model_edge(mdv(0, 0, 0, 1, 0, 0), 0);

      for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

      // div then mflo: busy and stalled for exactly DIV_C cycles.
      step(mdv(1, 1, 1, 0, 0, 0), "div start");
      for (int i = 0; i < DIV_C; i++) step(mdv(0, 0, 1, 0, MD_EN, MD_EN), "mflo busy");
      step(mdv(0, 0, 1, 0, 0, 0), "mflo free");

      // Reset in busy cycle 4 clears the tracker for the next cycle.
      step(mdv(1, 1, 1, 0, 0, 0), "div2 start");
      for (int i = 0; i < 3; i++) step(mdv(0, 0, 1, 0, MD_EN, MD_EN), "mflo2 busy");
      step(mdv(0, 0, 1, 1, MD_EN, MD_EN), "mflo2 reset");
      step(mdv(0, 0, 1, 0, 0, 0), "after reset");

      // mult immediately followed by div: div waits out the mult, then loads.
      step(mdv(1, 0, 1, 0, 0, 0), "mult start");
      for (int i = 0; i < MULT_C; i++) step(mdv(1, 1, 1, 0, MD_EN, MD_EN), "div held");
      step(mdv(1, 1, 1, 0, 0, 0), "div loads");
      for (int i = 0; i < DIV_C; i++) step(mdv(0, 0, 1, 0, MD_EN, MD_EN), "mflo3 busy");
      step(mdv(0, 0, 1, 0, 0, 0), "mflo3 free");

      // Random traffic against the reference model.
      for (int i = 0; i < 3000; i++) begin
         v.reset     = ($urandom_range(99) == 0);
         v.rs        = $urandom_range(4);
         v.rt        = $urandom_range(4);
         v.trs       = $urandom_range(3);
         v.trt       = $urandom_range(3);
         v.dst       = $urandom_range(4);
         v.tnew      = $urandom_range(3);
         v.md_start  = ($urandom_range(15) == 0);
         v.md_is_div = $urandom_range(1) != 0;
         v.md_use    = v.md_start || ($urandom_range(5) == 0);
         model_eval(v, v.e_stall, v.e_rs, v.e_rt, v.e_busy);
         step(v, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
